// File: rtl/neo_spike_detector.sv
// neo_spike_detector: sweeps the NEO result memory after a start pulse and
// emits every location whose signed value is strictly above a latched threshold.
// Latency: start edge -> address 0 compared next cycle; 1 cycle per miss; 1 + HOLD cycles per hit.
// Backpressure: a pending spike event parks the sweep in HOLD until spike_ready is seen high.
//
// Ports:
//   Clk, reset          clock (rising edge), asynchronous active-high reset
//   start, thresh       sweep request pulse and detection threshold (latched on accept)
//   raddr, rdata        result memory address / combinational read data
//   spike_valid/ready   event handshake; spike_addr / spike_value carry the event
//   spike_count         events accepted in the current/last sweep
//   busy, done          not-IDLE flag and one-cycle end-of-sweep pulse
//
// Optional feature: define NEO_REFRACTORY_EN to blank REFRACT addresses after
// each accepted spike (they are still stepped, one cycle each, but never hit).

module neo_spike_detector #(
  parameter int N       = 16,
  parameter int M       = 32,
  parameter int REFRACT = 4
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic signed [N-1:0]    thresh,
  output logic [$clog2(M)-1:0]   raddr,
  input  logic signed [N-1:0]    rdata,
  output logic                   spike_valid,
  input  logic                   spike_ready,
  output logic [$clog2(M)-1:0]   spike_addr,
  output logic signed [N-1:0]    spike_value,
  output logic [$clog2(M):0]     spike_count,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = $clog2(M);
  localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

  // Blanking length loaded after each accepted spike. With the feature off it
  // is zero, so the counter never leaves zero and every address is compared.
`ifdef NEO_REFRACTORY_EN
  localparam int REFR_LEN = REFRACT;
`else
  localparam int REFR_LEN = 0;
`endif
  localparam int RW = $clog2(REFRACT + 2);
  localparam logic [RW-1:0] REFR_LOAD = RW'(REFR_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic signed [N-1:0]   thr_q, thr_d;
  logic                  valid_q, valid_d;
  logic [AW-1:0]         saddr_q, saddr_d;
  logic signed [N-1:0]   sval_q, sval_d;
  logic [AW:0]           count_q, count_d;
  logic [RW-1:0]         refr_q, refr_d;

  logic                  at_last;
  logic [AW-1:0]         idx_inc;
  logic                  hit;
  logic                  blanked;

  assign at_last = (idx_q == LAST_ADDR);
  assign idx_inc = idx_q + 1'b1;
  assign blanked = (refr_q != '0);
  // Signed strict compare: equality is not a hit.
  assign hit     = !blanked && (rdata > thr_q);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      thr_q   <= '0;
      valid_q <= 1'b0;
      saddr_q <= '0;
      sval_q  <= '0;
      count_q <= '0;
      refr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      thr_q   <= thr_d;
      valid_q <= valid_d;
      saddr_q <= saddr_d;
      sval_q  <= sval_d;
      count_q <= count_d;
      refr_q  <= refr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    thr_d   = thr_q;
    valid_d = valid_q;
    saddr_d = saddr_q;
    sval_d  = sval_q;
    count_d = count_q;
    refr_d  = refr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          count_d = '0;
          thr_d   = thresh;
          refr_d  = '0;
        end
      end

      SCAN: begin
        if (hit) begin
          saddr_d = idx_q;
          sval_d  = rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          if (blanked) begin
            refr_d = refr_q - 1'b1;
          end
          // A blanking window running past the last address is simply clipped.
          if (at_last) begin
            state_d = DONE;
          end else begin
            idx_d = idx_inc;
          end
        end
      end

      HOLD: begin
        if (spike_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 1'b1;
          refr_d  = REFR_LOAD;
          if (at_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_inc;
            state_d = SCAN;
          end
        end
      end

      DONE: begin
        // Return the index to 0 so raddr reads 0 while idle.
        idx_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign raddr       = idx_q;
  assign spike_valid = valid_q;
  assign spike_addr  = saddr_q;
  assign spike_value = sval_q;
  assign spike_count = count_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: doc/neo_spike_detector.md
# neo_spike_detector

Consumes the NEO result memory once the NEO calculator signals completion. On a `start` pulse it sweeps the result memory address by address and compares each signed NEO value against a runtime threshold. Every location whose value exceeds the threshold is emitted as a spike event on a valid/ready output interface. It reports a spike count and a one-cycle `done` pulse per sweep, and sits between the NEO result memory and downstream spike sorting/logging.

## Interface
- `N`, 16, NEO value width (signed)
- `M`, 32, number of result memory locations; addresses 0..M-1
- `REFRACT`, 4, addresses skipped after a reported spike (used only with `NEO_REFRACTORY_EN`)
- `Clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle pulse from the NEO calculator `ready` output
- `thresh` in N signed: detection threshold; sampled at `start` acceptance and held for the sweep
- `raddr` out $clog2(M): result memory read address
- `rdata` in N signed: result memory data; combinational read, valid in the same cycle as `raddr`
- `spike_valid` out 1: spike event available
- `spike_ready` in 1: downstream accepts event
- `spike_addr` out $clog2(M): address of the spike
- `spike_value` out N signed: NEO value at the spike
- `spike_count` out $clog2(M)+1: spikes accepted in the current/last sweep
- `busy` out 1: high whenever the state is not IDLE
- `done` out 1: one-cycle pulse at end of sweep

## Operation
- States: IDLE, SCAN, HOLD, DONE. Index register `idx` (0..M-1) drives `raddr` directly.
- IDLE:
  - `start`=1 → SCAN; `idx`←0, `spike_count`←0, latch `thresh`.
  - Otherwise `raddr`=0.
- SCAN:
  - A hit is `rdata > thr_latched`, using a signed strict compare. Equal values are not hits. Negative values never hit unless the threshold is negative.
  - On a hit: register `spike_addr`←`idx` and `spike_value`←`rdata`, set `spike_valid`←1, then → HOLD.
  - On a miss with `idx`=M-1: → DONE.
  - On a miss otherwise: `idx`←`idx`+1.
- HOLD:
  - `spike_valid` stays high, and `spike_addr`/`spike_value` stay stable, until the edge where `spike_ready`=1.
  - At that edge: `spike_valid`←0 and `spike_count`←`spike_count`+1.
  - Then → DONE if `idx`=M-1, else `idx`←`idx`+1 → SCAN.
- DONE: `done`=1 for exactly one cycle, then → IDLE. `spike_count` holds until the next accepted `start`.
- `start` in any state other than IDLE is ignored (no queueing).
- `thresh` changes during a sweep have no effect.
- `spike_count` cannot overflow: its maximum is M, which fits in $clog2(M)+1 bits.
- Reset (asynchronous, any state): state←IDLE, `idx`←0.
  - All outputs go to 0: `raddr`, `spike_valid`, `spike_addr`, `spike_value`, `spike_count`, `busy`, `done`.
  - An in-flight event is dropped.

## Timing
- `start` sampled at edge E0 → SCAN from E0; address 0 is compared in the cycle after E0.
- Miss costs 1 cycle per address.
- Hit costs 1 SCAN cycle + HOLD cycles, where HOLD is ≥1 and equals 1 when `spike_ready` is already high.
- `spike_valid` rises at the edge following the hit compare.
- Transfer occurs at an edge where `spike_valid` and `spike_ready` are both high. The next address is compared in the following cycle.
- Zero-hit sweep:
  - `done` is high in cycle M+1 after E0.
  - `busy` is high for M+1 cycles.
- A hit at address M-1 → HOLD → DONE; `done` pulses after the transfer.
- `spike_ready` may be high while `spike_valid` is low; this has no effect.

## Configuration
- `NEO_REFRACTORY_EN` defined:
  - After a spike at address a is accepted, addresses a+1..a+REFRACT are still stepped at 1 cycle each but are not compared and cannot hit.
  - The skip is clipped at M-1; the sweep then ends normally through DONE.
- Undefined: every address is compared, and `REFRACT` is unused.

## Test plan
- Reset asserted mid-idle and released → all outputs 0, `raddr`=0, `busy`=0.
- M=32, all results 0, `thresh`=100, `start` pulse → no `spike_valid`; `done` high exactly 33 cycles after the start edge; `spike_count`=0.
- mem[5]=200, mem[6]=100, mem[7]=-300, `thresh`=100, `spike_ready`=1 → single event `spike_addr`=5, `spike_value`=200; `spike_count`=1.
- mem[3]=500, `spike_ready` held low 4 cycles after `spike_valid` rises, plus a second `start` pulse during HOLD →
  - `spike_valid` held with addr 3 / value 500 stable;
  - scan resumes after acceptance;
  - the second `start` is ignored;
  - one `done` pulse.
- mem[10..12]=150, `thresh`=100, REFRACT=4 → with `NEO_REFRACTORY_EN` only addr 10, count 1; without it events 10, 11, 12, count 3.
- Reset pulsed while `idx`=8 in SCAN → immediate IDLE, `busy`=0, `spike_count`=0; a new `start` sweeps again from address 0.
